// File: rtl/traffic_pkg.sv
// Shared types for the left-turn light controller and its lamp driver.
// Colour codes, fault codes and the colour-sequence legality rule.
package traffic_pkg;

  typedef enum logic [1:0] {
    GREEN           = 2'b00,
    YELLOW          = 2'b01,
    RED             = 2'b10,
    FLASHING_YELLOW = 2'b11
  } color_t;

  typedef enum logic [1:0] {
    F_NONE         = 2'b00,
    F_ILLEGAL      = 2'b01,
    F_SHORT_YELLOW = 2'b10
  } fault_t;

  // An unchanged colour is not a transition and therefore always legal.
  function automatic logic is_legal_transition(input color_t prev, input color_t cur);
    logic ok;
    ok = 1'b0;
    if (prev == cur) begin
      ok = 1'b1;
    end else begin
      case (prev)
        GREEN:           ok = (cur == YELLOW);
        YELLOW:          ok = (cur == RED);
        RED:             ok = (cur == GREEN) || (cur == FLASHING_YELLOW);
        FLASHING_YELLOW: ok = (cur == YELLOW);
        default:         ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/lamp_blinker.sv
// Blink phase generator: BLINK_HALF cycles on, BLINK_HALF cycles off.
// A restart forces the phase on so every blink sequence begins lit.
module lamp_blinker #(
  parameter int BLINK_HALF = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic phase
);

  localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (restart) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (cnt == CW'(BLINK_HALF - 1)) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/left_lamp_driver.sv
// Lamp driver and safety monitor for the left-turn light: decodes the colour
// code onto lamps, blinks flashing yellow, and latches faults into flashing red.
module left_lamp_driver
  import traffic_pkg::*;
#(
  parameter int BLINK_HALF = 2,
  parameter int MIN_YELLOW = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] light_color,
  input  logic       clear_fault,
  output logic       lamp_red,
  output logic       lamp_yellow,
  output logic       lamp_green,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam int DW = $clog2(MIN_YELLOW + 1);

  typedef enum logic [2:0] {
    S_RED,
    S_GREEN,
    S_YELLOW,
    S_FLASH,
    S_FAULT
  } lamp_state_t;

  color_t        cur;
  color_t        prev_color;
  lamp_state_t   state, state_n;
  logic [DW-1:0] dwell, dwell_n;
  fault_t        code_q, code_n;
  logic          fault_n;
  logic          restart;
  logic          blink_phase;
  logic          illegal, short_yellow;

  assign cur = color_t'(light_color);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_RED;
      prev_color <= RED;
      dwell      <= '0;
      fault      <= 1'b0;
      code_q     <= F_NONE;
    end else begin
      state      <= state_n;
      prev_color <= cur;
      dwell      <= dwell_n;
      fault      <= fault_n;
      code_q     <= code_n;
    end
  end

  always_comb begin
    state_n      = state;
    dwell_n      = dwell;
    fault_n      = fault;
    code_n       = code_q;
    restart      = 1'b0;
    illegal      = !is_legal_transition(prev_color, cur);
    short_yellow = (prev_color == YELLOW) && (cur == RED) && (dwell < DW'(MIN_YELLOW));

    // Dwell keeps tracking in fault mode so it is consistent once cleared.
    if (cur == YELLOW) begin
      if (prev_color != YELLOW)
        dwell_n = DW'(1);
      else if (dwell < DW'(MIN_YELLOW))
        dwell_n = dwell + DW'(1);
    end

    if (fault) begin
      if (clear_fault && (cur == RED)) begin
        fault_n = 1'b0;
        code_n  = F_NONE;
        state_n = S_RED;
      end
    end else if (illegal || short_yellow) begin
      fault_n = 1'b1;
      code_n  = illegal ? F_ILLEGAL : F_SHORT_YELLOW;
      state_n = S_FAULT;
      restart = 1'b1;
    end else begin
      case (cur)
        GREEN:           state_n = S_GREEN;
        YELLOW:          state_n = S_YELLOW;
        RED:             state_n = S_RED;
        FLASHING_YELLOW: state_n = S_FLASH;
        default:         state_n = S_RED;
      endcase
      restart = (cur == FLASHING_YELLOW) && (prev_color != FLASHING_YELLOW);
    end
  end

  lamp_blinker #(
    .BLINK_HALF(BLINK_HALF)
  ) u_blinker (
    .clk    (clk),
    .reset_n(reset_n),
    .restart(restart),
    .phase  (blink_phase)
  );

  assign lamp_red    = (state == S_RED) || ((state == S_FAULT) && blink_phase);
  assign lamp_yellow = (state == S_YELLOW) || ((state == S_FLASH) && blink_phase);
  assign lamp_green  = (state == S_GREEN);
  assign fault_code  = code_q;

endmodule

// File: tb/tb_left_lamp_driver.sv
// Scoreboard bench for left_lamp_driver: stimulus pushes the expected lamp and
// fault outputs for each edge, a monitor pops and compares after the edge.
module tb_left_lamp_driver;
  import traffic_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] light_color;
  logic       clear_fault;
  logic       lamp_red, lamp_yellow, lamp_green, fault;
  logic [1:0] fault_code;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [5:0] exp;
  } exp_t;

  exp_t sb[$];

  // {red, yellow, green, fault, code}
  localparam logic [5:0] E_RED   = 6'b100_0_00;
  localparam logic [5:0] E_GRN   = 6'b001_0_00;
  localparam logic [5:0] E_YEL   = 6'b010_0_00;
  localparam logic [5:0] E_DARK  = 6'b000_0_00;
  localparam logic [5:0] E_FI_ON = 6'b100_1_01;
  localparam logic [5:0] E_FI_OF = 6'b000_1_01;
  localparam logic [5:0] E_FS_ON = 6'b100_1_10;
  localparam logic [5:0] E_FS_OF = 6'b000_1_10;

  left_lamp_driver #(
    .BLINK_HALF(2),
    .MIN_YELLOW(3)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .light_color(light_color),
    .clear_fault(clear_fault),
    .lamp_red   (lamp_red),
    .lamp_yellow(lamp_yellow),
    .lamp_green (lamp_green),
    .fault      (fault),
    .fault_code (fault_code)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] outs();
    return {lamp_red, lamp_yellow, lamp_green, fault, fault_code};
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got rygf_code=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; drives one sample and queues the post-edge expectation.
  task automatic step(input color_t c, input logic clr, input logic [5:0] exp, input string name);
    exp_t e;
    light_color = c;
    clear_fault = clr;
    e.name = name;
    e.exp  = exp;
    sb.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check(e.name, outs(), e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] fy_pat [8];
    fy_pat = '{2'd1, 2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0};

    reset_n     = 1'b0;
    light_color = RED;
    clear_fault = 1'b0;
    #1;
    check("reset_state", outs(), E_RED);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Normal cycle: R x4, G x6, Y x3, R
    for (int unsigned i = 0; i < 4; i++) step(RED,   1'b0, E_RED, "seq_red");
    for (int unsigned i = 0; i < 6; i++) step(GREEN, 1'b0, E_GRN, "seq_green");
    for (int unsigned i = 0; i < 3; i++) step(YELLOW,1'b0, E_YEL, "seq_yellow");
    step(RED, 1'b0, E_RED, "seq_yel_to_red");

    // Flashing yellow from red, then FY->Y->R
    for (int unsigned i = 0; i < 8; i++)
      step(FLASHING_YELLOW, 1'b0, fy_pat[i][0] ? E_YEL : E_DARK, "flash_yellow");
    step(YELLOW, 1'b0, E_YEL, "fy_to_yellow");
    step(YELLOW, 1'b0, E_YEL, "fy_yellow2");
    step(YELLOW, 1'b0, E_YEL, "fy_yellow3");
    step(RED,    1'b0, E_RED, "fy_yel_to_red");

    // Illegal G->R, then fault red blinks regardless of input
    for (int unsigned i = 0; i < 3; i++) step(GREEN, 1'b0, E_GRN, "pre_illegal_green");
    step(RED,             1'b0, E_FI_ON, "illegal_entry");
    step(GREEN,           1'b0, E_FI_ON, "fault_blink1");
    step(YELLOW,          1'b0, E_FI_OF, "fault_blink2");
    step(FLASHING_YELLOW, 1'b0, E_FI_OF, "fault_blink3");
    step(GREEN,           1'b0, E_FI_ON, "fault_blink4");
    step(YELLOW,          1'b0, E_FI_ON, "fault_blink5");
    step(RED,             1'b0, E_FI_OF, "fault_red_no_clear");
    step(GREEN,           1'b1, E_FI_OF, "clear_ignored_green");
    step(RED,             1'b1, E_RED,   "clear_wins_on_red");
    step(RED,             1'b0, E_RED,   "after_clear_red");
    step(GREEN,           1'b1, E_GRN,   "clear_ignored_no_fault");

    // Short yellow: G, Y x2, R
    step(YELLOW, 1'b0, E_YEL,   "short_y1");
    step(YELLOW, 1'b0, E_YEL,   "short_y2");
    step(RED,    1'b0, E_FS_ON, "short_yellow_entry");
    step(GREEN,  1'b0, E_FS_ON, "short_keep_code1");
    step(YELLOW, 1'b0, E_FS_OF, "short_keep_code2");
    step(RED,    1'b1, E_RED,   "short_clear");

    // Full-length yellow is legal
    step(GREEN,  1'b0, E_GRN, "long_green");
    step(YELLOW, 1'b0, E_YEL, "long_y1");
    step(YELLOW, 1'b0, E_YEL, "long_y2");
    step(YELLOW, 1'b0, E_YEL, "long_y3");
    step(RED,    1'b0, E_RED, "long_yel_to_red");

    // Fault via R->Y, then asynchronous reset mid-cycle
    step(YELLOW, 1'b0, E_FI_ON, "illegal_r_to_y");
    step(GREEN,  1'b0, E_FI_ON, "fault_before_reset");
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", outs(), E_RED);
    @(negedge clk);
    reset_n = 1'b1;
    step(GREEN, 1'b0, E_GRN, "post_reset_r_to_g");
    step(GREEN, 1'b0, E_GRN, "post_reset_hold");

    @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
